spi_sp_ram: RTL and testbench

- Single-port RAM that sits directly downstream of the SPI slave and consumes its 10-bit command/data words (rx_data/rx_valid).
- Returns read data to the slave on dout/tx_valid, which the slave shifts out on MISO.
- Decodes four commands from the two MSBs: write address, write data, read address, read data.
- Holds separate write/read address registers and flags out-of-sequence commands.

---
 rtl/shared_pkg.sv | 17 +
 rtl/spi_ram_array.sv | 51 +++++
 rtl/spi_sp_ram.sv | 99 +++++++++
 tb/tb_spi_sp_ram.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// Shared definitions for the SPI single-port RAM.
//   MEM_WIDTH / MEM_DEPTH / ADDR_SIZE : default geometry of the RAM.
//   ram_cmd_e : two-bit command carried in the top bits of each SPI word.
package shared_pkg;

    localparam int MEM_WIDTH = 8;
    localparam int MEM_DEPTH = 256;
    localparam int ADDR_SIZE = 8;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } ram_cmd_e;

endpackage

// File: rtl/spi_ram_array.sv
// Storage array for spi_sp_ram: synchronous write, registered synchronous read.
// Ports:
//   clk, rst     : clock and asynchronous active-high reset (read register only)
//   we, waddr, wdata : write port; writes beyond DEPTH are dropped
//   re, raddr    : read request; rdata updates on the same edge
//   rdata        : registered read data; 0 for addresses beyond DEPTH
// Memory contents are deliberately not reset.
module spi_ram_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic          w_ok;
    logic          r_ok;

    // Only a partially populated address space needs a bounds check.
    generate
        if (DEPTH < 2**AW) begin : g_part
            localparam logic [AW-1:0] LIM = AW'(DEPTH);
            assign w_ok = waddr < LIM;
            assign r_ok = raddr < LIM;
        end else begin : g_full
            assign w_ok = 1'b1;
            assign r_ok = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we && w_ok)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= r_ok ? mem[raddr] : '0;
    end

endmodule

// File: rtl/spi_sp_ram.sv
// Single-port RAM fed by the SPI slave's 10-bit command/data words.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   din       : {command[1:0], payload[MEM_WIDTH-1:0]}
//   rx_valid  : din valid; one command accepted per cycle
//   dout      : read data back to the slave
//   tx_valid  : dout valid; held until the next non-read command
//   cmd_err   : one-cycle pulse after an out-of-sequence / out-of-range command
module spi_sp_ram
    import shared_pkg::*;
#(
    parameter int MEM_DEPTH = shared_pkg::MEM_DEPTH,
    parameter int ADDR_SIZE = shared_pkg::ADDR_SIZE,
    parameter int MEM_WIDTH = shared_pkg::MEM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MEM_WIDTH+1:0] din,
    input  logic                 rx_valid,
    output logic [MEM_WIDTH-1:0] dout,
    output logic                 tx_valid,
    output logic                 cmd_err
);

    ram_cmd_e               cmd;
    logic [MEM_WIDTH-1:0]   payload;
    logic [ADDR_SIZE-1:0]   wr_addr;
    logic [ADDR_SIZE-1:0]   rd_addr;
    logic                   wr_addr_vld;
    logic                   rd_addr_vld;
    logic                   wr_ok;
    logic                   rd_ok;
    logic                   do_wr;
    logic                   do_rd;

    assign cmd     = ram_cmd_e'(din[MEM_WIDTH+1:MEM_WIDTH]);
    assign payload = din[MEM_WIDTH-1:0];
    assign do_wr   = rx_valid && (cmd == WR_DATA);
    assign do_rd   = rx_valid && (cmd == RD_DATA);

    generate
        if (MEM_DEPTH < 2**ADDR_SIZE) begin : g_part
            localparam logic [ADDR_SIZE-1:0] LIM = ADDR_SIZE'(MEM_DEPTH);
            assign wr_ok = wr_addr < LIM;
            assign rd_ok = rd_addr < LIM;
        end else begin : g_full
            assign wr_ok = 1'b1;
            assign rd_ok = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr     <= '0;
            rd_addr     <= '0;
            wr_addr_vld <= 1'b0;
            rd_addr_vld <= 1'b0;
            tx_valid    <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            if (rx_valid) begin
                // Any accepted command other than a data read retires tx_valid.
                tx_valid <= (cmd == RD_DATA);
                unique case (cmd)
                    WR_ADDR: begin
                        wr_addr     <= payload[ADDR_SIZE-1:0];
                        wr_addr_vld <= 1'b1;
                    end
                    WR_DATA: cmd_err <= !wr_addr_vld || !wr_ok;
                    RD_ADDR: begin
                        rd_addr     <= payload[ADDR_SIZE-1:0];
                        rd_addr_vld <= 1'b1;
                    end
                    RD_DATA: cmd_err <= !rd_addr_vld || !rd_ok;
                    default: ;
                endcase
            end
        end
    end

    // A write still lands at wr_addr even when out of sequence; the array
    // drops out-of-range addresses on its own.
    spi_ram_array #(
        .DEPTH (MEM_DEPTH),
        .AW    (ADDR_SIZE),
        .DW    (MEM_WIDTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (do_wr),
        .waddr (wr_addr),
        .wdata (payload),
        .re    (do_rd),
        .raddr (rd_addr),
        .rdata (dout)
    );

endmodule

// File: tb/tb_spi_sp_ram.sv
module tb_spi_sp_ram;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] dout;
    logic       tx_valid;
    logic       cmd_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       is_rd;
        logic       chk_d;
        logic [7:0] d;
        logic       err;
    } exp_t;

    exp_t q[$];

    spi_sp_ram dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid),
        .cmd_err  (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one command for one cycle and record what the monitor should see.
    task automatic send(input logic [9:0] w, input logic chk_d, input logic [7:0] d, input logic err);
        exp_t e;
        @(negedge clk);
        din      = w;
        rx_valid = 1'b1;
        e.is_rd  = (w[9:8] == 2'b11);
        e.chk_d  = chk_d;
        e.d      = d;
        e.err    = err;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx_valid = 1'b0;
        din      = '0;
        if (n > 1) repeat (n - 1) @(negedge clk);
    endtask

    // Monitor: every accepted command produces one response one edge later.
    always @(posedge clk) begin
        logic acc;
        exp_t e;
        acc = rx_valid && !rst;
        #1;
        if (!rst) begin
            if (acc) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: command seen with empty queue at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("cmd_err", 32'(cmd_err), 32'(e.err));
                    chk("tx_valid", 32'(tx_valid), 32'(e.is_rd));
                    if (e.is_rd && e.chk_d) chk("dout", 32'(dout), 32'(e.d));
                end
            end else begin
                chk("cmd_err_idle", 32'(cmd_err), 32'd0);
            end
        end
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_cmd_err", 32'(cmd_err), 32'd0);
        rst = 1'b0;

        // Fresh-state read: no read address yet, data is undefined.
        send(10'h300, 1'b0, 8'h00, 1'b1);
        idle(2);
        chk("fresh_tx_hold", 32'(tx_valid), 32'd1);

        // Write data with no write address: goes to address 0 and flags.
        send(10'h1FF, 1'b0, 8'h00, 1'b1);
        send(10'h200, 1'b0, 8'h00, 1'b0);
        send(10'h300, 1'b1, 8'hFF, 1'b0);

        // Basic write/read.
        send(10'h005, 1'b0, 8'h00, 1'b0);
        send(10'h1A5, 1'b0, 8'h00, 1'b0);
        send(10'h205, 1'b0, 8'h00, 1'b0);
        send(10'h300, 1'b1, 8'hA5, 1'b0);

        // tx_valid / dout held while idle.
        for (int i = 0; i < 10; i++) begin
            idle(1);
            chk("hold_tx_valid", 32'(tx_valid), 32'd1);
            chk("hold_dout", 32'(dout), 32'hA5);
        end
        send(10'h010, 1'b0, 8'h00, 1'b0);

        // Back-to-back, read right after write to the same address.
        send(10'h03C, 1'b0, 8'h00, 1'b0);
        send(10'h23C, 1'b0, 8'h00, 1'b0);
        send(10'h177, 1'b0, 8'h00, 1'b0);
        send(10'h300, 1'b1, 8'h77, 1'b0);
        idle(1);
        chk("b2b_tx_valid", 32'(tx_valid), 32'd1);

        // Reset mid-read: outputs drop without waiting for a clock.
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_dout", 32'(dout), 32'd0);
        chk("mid_rst_cmd_err", 32'(cmd_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Full sweep.
        for (int a = 0; a < 256; a++) begin
            send(10'(a), 1'b0, 8'h00, 1'b0);
            send({2'b01, 8'(a) ^ 8'h5A}, 1'b0, 8'h00, 1'b0);
        end
        for (int a = 0; a < 256; a++) begin
            send({2'b10, 8'(a)}, 1'b0, 8'h00, 1'b0);
            send(10'h300, 1'b1, 8'(a) ^ 8'h5A, 1'b0);
        end
        idle(1);

        // Drain with a bounded wait.
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
